// File: rtl/bcd_updown_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_if
//
// Bundles the control, load and status signals of bcd_updown_counter.
// Clock and reset are not part of the bundle; they stay plain module ports.
//
// Parameters:
//   WIDTH    bits per digit
//   DIGITS   number of cascaded digits
//
// Signals:
//   EN        count enable                          (master -> slave)
//   UP        direction, 1 = up, 0 = down           (master -> slave)
//   LOAD      synchronous parallel load             (master -> slave)
//   LOAD_VAL  load value, one WIDTH field per digit (master -> slave)
//   ONESHOT   1 = stop at terminal count            (master -> slave)
//   out       registered counter value              (slave -> master)
//   TC        terminal count, combinational         (slave -> master)
//   CO        carry/borrow out for cascading        (slave -> master)
//   DONE      sticky one-shot completion flag       (slave -> master)
// ---------------------------------------------------------------------------
interface bcd_updown_counter_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 1
);
  logic                      EN;
  logic                      UP;
  logic                      LOAD;
  logic [DIGITS*WIDTH-1:0]   LOAD_VAL;
  logic                      ONESHOT;
  logic [DIGITS*WIDTH-1:0]   out;
  logic                      TC;
  logic                      CO;
  logic                      DONE;

  modport master (
    output EN, UP, LOAD, LOAD_VAL, ONESHOT,
    input  out, TC, CO, DONE
  );

  modport slave (
    input  EN, UP, LOAD, LOAD_VAL, ONESHOT,
    output out, TC, CO, DONE
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Cascadable multi-digit modulo-MODULUS up/down counter with synchronous
// load (with per-digit clamping), count enable, direction control and a
// one-shot mode that stops at the terminal count and raises a sticky DONE.
// MODULUS = 10 gives a BCD counter that can drive digit displays directly.
//
// Parameters:
//   WIDTH    bits per digit
//   MODULUS  count modulus per digit, legal range 2 .. 2**WIDTH
//   DIGITS   number of digits; digit 0 is out[WIDTH-1:0]
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   RESET    synchronous active-high reset (out = 0, DONE = 0)
//   bus      slave side of bcd_updown_counter_if (EN, UP, LOAD, LOAD_VAL,
//            ONESHOT in; out, TC, CO, DONE out)
//
// Priority on each edge: RESET > LOAD > count (EN & ~DONE) > hold.
// TC and CO are combinational from the registered digits, UP, EN and DONE.
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIGITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bcd_updown_counter_if.slave  bus
);

  // Largest legal digit value, and the modulus widened by one bit so that
  // MODULUS = 2**WIDTH stays representable in the clamp comparison.
  localparam logic [WIDTH-1:0] MAX_DIGIT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]        term_val;
  logic [DIGITS-1:0]       at_term;
  // chain[k] = all digits below k sit at the terminal value, so digit k
  // steps; chain[DIGITS] is the whole-counter terminal count.
  logic [DIGITS:0]         chain;
  logic [DIGITS*WIDTH-1:0] out_vec;
  logic                    step_en;
  logic                    freeze;
  logic                    done_reg;
  logic                    done_next;

  assign term_val = bus.UP ? MAX_DIGIT : '0;
  assign chain[0] = 1'b1;
  assign step_en  = bus.EN & ~done_reg;
  // In one-shot mode the step taken at terminal count leaves out unchanged
  // and sets DONE instead of wrapping.
  assign freeze   = bus.ONESHOT & chain[DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [WIDTH-1:0] digit_reg;
      logic [WIDTH-1:0] digit_next;
      logic [WIDTH-1:0] load_field;
      logic [WIDTH-1:0] load_clamped;
      logic [WIDTH-1:0] step_val;

      assign load_field   = bus.LOAD_VAL[gi*WIDTH +: WIDTH];
      assign load_clamped = ({1'b0, load_field} >= MOD_EXT) ? MAX_DIGIT : load_field;
      assign at_term[gi]  = (digit_reg == term_val);
      assign chain[gi+1]  = chain[gi] & at_term[gi];

      always_comb begin
        step_val = digit_reg;
        if (bus.UP) begin
          step_val = at_term[gi] ? '0 : digit_reg + 1'b1;
        end else begin
          step_val = at_term[gi] ? MAX_DIGIT : digit_reg - 1'b1;
        end
      end

      always_comb begin
        digit_next = digit_reg;
        if (bus.LOAD) begin
          digit_next = load_clamped;
        end else if (step_en && !freeze && chain[gi]) begin
          digit_next = step_val;
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          digit_reg <= '0;
        end else begin
          digit_reg <= digit_next;
        end
      end

      assign out_vec[gi*WIDTH +: WIDTH] = digit_reg;
    end
  endgenerate

  always_comb begin
    done_next = done_reg;
    if (bus.LOAD) begin
      done_next = 1'b0;
    end else if (step_en && freeze) begin
      done_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end

  assign bus.out  = out_vec;
  assign bus.TC   = chain[DIGITS];
  assign bus.CO   = chain[DIGITS] & step_en;
  assign bus.DONE = done_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Drives a 1-digit and a 2-digit BCD counter from the same stimulus. A model
// treats each counter as one integer modulo 10**DIGITS and is compared with
// both DUTs on every falling edge; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load, oneshot;
  logic [7:0] lv;

  int  checks = 0;
  int  errors = 0;
  bit  chk_on = 1'b0;

  // model state: index 0 = 1-digit counter, index 1 = 2-digit counter
  int  mv [2] = '{0, 0};
  bit  md [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.WIDTH(4), .DIGITS(1)) bus1 ();
  bcd_updown_counter_if #(.WIDTH(4), .DIGITS(2)) bus2 ();

  assign bus1.EN = en;  assign bus1.UP = up;  assign bus1.LOAD = load;
  assign bus1.ONESHOT = oneshot;  assign bus1.LOAD_VAL = lv[3:0];
  assign bus2.EN = en;  assign bus2.UP = up;  assign bus2.LOAD = load;
  assign bus2.ONESHOT = oneshot;  assign bus2.LOAD_VAL = lv;

  bcd_updown_counter #(.WIDTH(4), .MODULUS(10), .DIGITS(1)) dut1 (
    .CLK(clk), .RESET(rst), .bus(bus1.slave)
  );
  bcd_updown_counter #(.WIDTH(4), .MODULUS(10), .DIGITS(2)) dut2 (
    .CLK(clk), .RESET(rst), .bus(bus2.slave)
  );

  function automatic int span(int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // LOAD_VAL fields -> integer value, each field clamped to 9
  function automatic int to_val(logic [7:0] v, int n);
    int r = 0;
    int p = 1;
    int f;
    for (int k = 0; k < n; k++) begin
      f = int'(v[k*4 +: 4]);
      if (f > 9) f = 9;
      r = r + f * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bits(int v, int n);
    logic [7:0] r = '0;
    int x = v;
    for (int k = 0; k < n; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit model_tc(int v, int n, logic dir_up);
    return dir_up ? (v == span(n) - 1) : (v == 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model, advanced on each rising edge
  always @(posedge clk) begin
    int nv;
    bit nd;
    for (int i = 0; i < 2; i++) begin
      nv = mv[i];
      nd = md[i];
      if (rst) begin
        nv = 0;
        nd = 1'b0;
      end else if (load) begin
        nv = to_val(lv, i + 1);
        nd = 1'b0;
      end else if (en && !md[i]) begin
        if (oneshot && model_tc(mv[i], i + 1, up)) nd = 1'b1;
        else if (up) nv = (mv[i] + 1) % span(i + 1);
        else nv = (mv[i] + span(i + 1) - 1) % span(i + 1);
      end
      mv[i] <= nv;
      md[i] <= nd;
    end
  end

  // cycle-by-cycle compare against the model
  always @(negedge clk) begin
    bit t0, t1;
    if (chk_on) begin
      t0 = model_tc(mv[0], 1, up);
      t1 = model_tc(mv[1], 2, up);
      chk("m_out1",  {28'd0, bus1.out}, {24'd0, to_bits(mv[0], 1)});
      chk("m_tc1",   {31'd0, bus1.TC},  {31'd0, t0});
      chk("m_co1",   {31'd0, bus1.CO},  {31'd0, t0 & en & ~md[0]});
      chk("m_done1", {31'd0, bus1.DONE}, {31'd0, md[0]});
      chk("m_out2",  {24'd0, bus2.out}, {24'd0, to_bits(mv[1], 2)});
      chk("m_tc2",   {31'd0, bus2.TC},  {31'd0, t1});
      chk("m_co2",   {31'd0, bus2.CO},  {31'd0, t1 & en & ~md[1]});
      chk("m_done2", {31'd0, bus2.DONE}, {31'd0, md[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int dwrap [11] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
    int casc  [3]  = '{'h19, 'h20, 'h21};

    // reset dominates LOAD and EN
    rst = 1'b1; en = 1'b1; load = 1'b1; lv = 8'h07; up = 1'b0; oneshot = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_out2", {24'd0, bus2.out}, 32'h00);
    chk("rst_out1", {28'd0, bus1.out}, 32'h0);
    chk("rst_done2", {31'd0, bus2.DONE}, 32'd0);
    chk("rst_tc_down", {31'd0, bus2.TC}, 32'd1);
    up = 1'b1;
    #1;
    chk("rst_tc_up", {31'd0, bus2.TC}, 32'd0);

    // one-digit down wrap
    rst = 1'b0; load = 1'b1; lv = 8'h09; up = 1'b0; en = 1'b1;
    tick();
    chk("dwrap_load", {28'd0, bus1.out}, 32'h9);
    load = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("dwrap_out", {28'd0, bus1.out}, 32'(dwrap[k]));
      chk("dwrap_tc", {31'd0, bus1.TC}, (dwrap[k] == 0) ? 32'd1 : 32'd0);
    end
    chk("dwrap_done", {31'd0, bus1.DONE}, 32'd0);

    // two-digit up cascade; EN is ignored in the load cycle
    load = 1'b1; lv = 8'h18; up = 1'b1; en = 1'b1;
    tick();
    chk("casc_load", {24'd0, bus2.out}, 32'h18);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("casc_out", {24'd0, bus2.out}, 32'(casc[k]));
    end
    load = 1'b1; lv = 8'h99;
    tick();
    chk("casc_99", {24'd0, bus2.out}, 32'h99);
    chk("casc_tc99", {31'd0, bus2.TC}, 32'd1);
    chk("casc_co99", {31'd0, bus2.CO}, 32'd1);
    load = 1'b0;
    tick();
    chk("casc_wrap", {24'd0, bus2.out}, 32'h00);
    chk("casc_tc00", {31'd0, bus2.TC}, 32'd0);

    // one-shot down count with sticky DONE
    load = 1'b1; lv = 8'h02; oneshot = 1'b1; up = 1'b0; en = 1'b1;
    tick();
    chk("os_load", {24'd0, bus2.out}, 32'h02);
    load = 1'b0;
    tick();
    chk("os_01", {24'd0, bus2.out}, 32'h01);
    tick();
    chk("os_00", {24'd0, bus2.out}, 32'h00);
    chk("os_tc", {31'd0, bus2.TC}, 32'd1);
    chk("os_co_pre", {31'd0, bus2.CO}, 32'd1);
    chk("os_done_pre", {31'd0, bus2.DONE}, 32'd0);
    tick();
    chk("os_hold", {24'd0, bus2.out}, 32'h00);
    chk("os_done", {31'd0, bus2.DONE}, 32'd1);
    chk("os_co", {31'd0, bus2.CO}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) oneshot = 1'b0;
      tick();
      chk("os_hold_n", {24'd0, bus2.out}, 32'h00);
      chk("os_done_n", {31'd0, bus2.DONE}, 32'd1);
      chk("os_co_n", {31'd0, bus2.CO}, 32'd0);
    end
    oneshot = 1'b1; load = 1'b1; lv = 8'h05;
    tick();
    chk("os_reload", {24'd0, bus2.out}, 32'h05);
    chk("os_reload_done", {31'd0, bus2.DONE}, 32'd0);
    load = 1'b0;
    tick();
    chk("os_resume", {24'd0, bus2.out}, 32'h04);

    // load clamp
    oneshot = 1'b0; en = 1'b0; load = 1'b1; lv = 8'hFC;
    tick();
    chk("clamp_fc", {24'd0, bus2.out}, 32'h99);
    chk("clamp_c1", {28'd0, bus1.out}, 32'h9);
    lv = 8'h3A;
    tick();
    chk("clamp_3a", {24'd0, bus2.out}, 32'h39);
    chk("clamp_a1", {28'd0, bus1.out}, 32'h9);

    // direction change and EN gating
    lv = 8'h04; up = 1'b1;
    tick();
    chk("dir_load", {24'd0, bus2.out}, 32'h04);
    load = 1'b0; en = 1'b1;
    tick();
    chk("dir_05", {24'd0, bus2.out}, 32'h05);
    tick();
    chk("dir_06", {24'd0, bus2.out}, 32'h06);
    up = 1'b0;
    tick();
    chk("dir_dn05", {24'd0, bus2.out}, 32'h05);
    tick();
    chk("dir_dn04", {24'd0, bus2.out}, 32'h04);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_hold", {24'd0, bus2.out}, 32'h04);
    end

    // two-digit down wrap with ONESHOT=0
    load = 1'b1; lv = 8'h00; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("dn_full_wrap", {24'd0, bus2.out}, 32'h99);
    chk("dn_full_done", {31'd0, bus2.DONE}, 32'd0);

    // reset mid-count together with LOAD
    rst = 1'b1; load = 1'b1; lv = 8'h55;
    tick();
    chk("rst_mid", {24'd0, bus2.out}, 32'h00);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
